// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and downstream pixel/video logic.
// The generator side consumes the pixel-rate enable and drives sync, data enable and position.
interface vga_timing_if #(
  parameter int CNT_W = 12
) ();
  logic             pixel_en;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pixel_en,
    output hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output pixel_en,
    input  hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA/DVI raster timing: two-level h/v position counter with registered,
// zero-latency sync/de/start decode, advancing only on pixel_en.
//
// phase  | h range (v uses the same layout with V_ parameters)
// ACTIVE | [0, H_ACTIVE)
// FRONT  | [H_ACTIVE, H_ACTIVE+H_FRONT)
// SYNC   | [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC)
// BACK   | [H_ACTIVE+H_FRONT+H_SYNC, H_TOTAL)
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CNT_W      = 12
) (
  input  logic        clock,
  input  logic        reset,
  vga_timing_if.master bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_END    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_END    = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);

  cnt_t h, v;
  cnt_t h_nxt, v_nxt;
  logic hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic hsync_nxt, vsync_nxt, de_nxt, line_start_nxt, frame_start_nxt;

  // Wrap by explicit compare so non-power-of-two totals never rely on overflow.
  always_comb begin
    h_nxt = h + cnt_t'(1);
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + cnt_t'(1);
    end
  end

  // Decode the position being entered so the registered outputs line up with x/y.
  always_comb begin
    hsync_nxt       = ((h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END)) ? HS_ON : ~HS_ON;
    vsync_nxt       = ((v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END)) ? VS_ON : ~VS_ON;
    de_nxt          = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    line_start_nxt  = (h_nxt == '0);
    frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  // Reset position is the last back-porch pixel, so sync/de/starts are all inactive there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h             <= H_LAST;
      v             <= V_LAST;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (bus.pixel_en) begin
      h             <= h_nxt;
      v             <= v_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      de_q          <= de_nxt;
      line_start_q  <= line_start_nxt;
      frame_start_q <= frame_start_nxt;
    end
  end

  assign bus.x           = h;
  assign bus.y           = v;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: default 800x525 timing and a tiny 8x6 config
// sharing clock and reset, with independent pixel enables.
module tb_vga_timing_generator;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vga_timing_if #(.CNT_W(12)) vd ();
  vga_timing_if #(.CNT_W(12)) vt ();

  vga_timing_generator #(.CNT_W(12)) dut_dflt (
    .clock (clock),
    .reset (reset),
    .bus   (vd)
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .CNT_W(12)
  ) dut_tiny (
    .clock (clock),
    .reset (reset),
    .bus   (vt)
  );

  int pass_cnt = 0;
  int total    = 0;

  typedef logic [28:0] obs_t;  // {x, y, de, hsync, vsync, line_start, frame_start}

  typedef struct {
    bit en;
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } vec_t;

  function automatic obs_t mk(int x, int y, bit de, bit hs, bit vs, bit ls, bit fs);
    return {12'(x), 12'(y), de, hs, vs, ls, fs};
  endfunction

  function automatic obs_t get_d();
    return {vd.x, vd.y, vd.de, vd.hsync, vd.vsync, vd.line_start, vd.frame_start};
  endfunction

  function automatic obs_t get_t();
    return {vt.x, vt.y, vt.de, vt.hsync, vt.vsync, vt.line_start, vt.frame_start};
  endfunction

  // Default 640x480 timing, active-low syncs: hsync low 656..751, vsync low 490..491.
  function automatic obs_t dflt_exp(int h, int v);
    return mk(h, v, (h < 640) && (v < 480), !((h >= 656) && (h <= 751)),
              !((v == 490) || (v == 491)), h == 0, (h == 0) && (v == 0));
  endfunction

  // Tiny config: 8-pixel lines, 6-line frame, hsync active-high at x=5,6, vsync low at y=4.
  function automatic obs_t tiny_exp(int h, int v);
    return mk(h, v, (h < 4) && (v < 3), (h == 5) || (h == 6), v != 4,
              h == 0, (h == 0) && (v == 0));
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h (x,y,de,hs,vs,ls,fs)", name, act, exp);
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[6];
  int mx, my, th, tv;
  int fs_cnt, ls_cnt, de_cnt, hs_cnt;

  initial begin
    tbl[0] = '{1, 0, 0, 1, 1, 1, 1, 1};
    tbl[1] = '{0, 0, 0, 1, 1, 1, 1, 1};
    tbl[2] = '{1, 1, 0, 1, 1, 1, 0, 0};
    tbl[3] = '{1, 2, 0, 1, 1, 1, 0, 0};
    tbl[4] = '{0, 2, 0, 1, 1, 1, 0, 0};
    tbl[5] = '{1, 3, 0, 1, 1, 1, 0, 0};

    reset       = 1'b0;
    vd.pixel_en = 1'b0;
    vt.pixel_en = 1'b0;
    repeat (3) tick();
    check("reset_dflt", get_d(), mk(799, 524, 0, 1, 1, 0, 0));
    check("reset_tiny", get_t(), mk(7, 5, 0, 0, 1, 0, 0));

    vd.pixel_en = 1'b1;
    vt.pixel_en = 1'b1;
    tick();
    check("reset_en_dflt", get_d(), mk(799, 524, 0, 1, 1, 0, 0));
    check("reset_en_tiny", get_t(), mk(7, 5, 0, 0, 1, 0, 0));

    reset       = 1'b1;
    vd.pixel_en = 1'b0;
    vt.pixel_en = 1'b0;
    tick();
    check("release_hold_dflt", get_d(), mk(799, 524, 0, 1, 1, 0, 0));

    // Wrap corner (799,524)->(0,0), then gating and first increments.
    foreach (tbl[i]) begin
      vd.pixel_en = tbl[i].en;
      tick();
      check($sformatf("tbl%0d", i), get_d(),
            mk(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs));
    end
    check("tiny_idle", get_t(), mk(7, 5, 0, 0, 1, 0, 0));

    // Sweep the rest of line 0 into line 1: hsync and de boundaries, line wrap.
    mx = 3;
    my = 0;
    vd.pixel_en = 1'b1;
    for (int k = 0; k < 802; k++) begin
      if (mx == 799) begin mx = 0; my++; end
      else mx++;
      tick();
      check("dflt_line", get_d(), dflt_exp(mx, my));
    end
    vd.pixel_en = 1'b0;
    check_int("dflt_line_end_x", int'(vd.x), 5);

    // Tiny config, two full frames at one pixel per clock.
    th = 7;
    tv = 5;
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_cnt = 0;
    vt.pixel_en = 1'b1;
    for (int k = 0; k < 96; k++) begin
      if (th == 7) begin th = 0; tv = (tv == 5) ? 0 : tv + 1; end
      else th++;
      tick();
      check("tiny_run", get_t(), tiny_exp(th, tv));
      fs_cnt += int'(vt.frame_start);
      ls_cnt += int'(vt.line_start);
      de_cnt += int'(vt.de);
      hs_cnt += int'(vt.hsync);
    end
    check_int("tiny_frame_starts", fs_cnt, 2);
    check_int("tiny_line_starts", ls_cnt, 12);
    check_int("tiny_de_count", de_cnt, 24);
    check_int("tiny_hsync_count", hs_cnt, 24);

    // Enable every third clock: outputs must hold between enabled edges.
    for (int k = 0; k < 150; k++) begin
      vt.pixel_en = (k % 3 == 0);
      if (k % 3 == 0) begin
        if (th == 7) begin th = 0; tv = (tv == 5) ? 0 : tv + 1; end
        else th++;
      end
      tick();
      check("tiny_gated", get_t(), tiny_exp(th, tv));
    end

    // Asynchronous reset mid-frame, asserted between clock edges.
    vd.pixel_en = 1'b1;
    vt.pixel_en = 1'b1;
    repeat (20) tick();
    check_int("pre_reset_not_home", int'(vd.x), 25);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_dflt", get_d(), mk(799, 524, 0, 1, 1, 0, 0));
    check("async_reset_tiny", get_t(), mk(7, 5, 0, 0, 1, 0, 0));
    tick();
    check("reset_held_dflt", get_d(), mk(799, 524, 0, 1, 1, 0, 0));
    reset = 1'b1;
    tick();
    check("restart_dflt", get_d(), dflt_exp(0, 0));
    check("restart_tiny", get_t(), tiny_exp(0, 0));
    tick();
    check("restart_next_dflt", get_d(), dflt_exp(1, 0));
    check("restart_next_tiny", get_t(), tiny_exp(1, 0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
